// File: rtl/lcd_spi_stream_if.sv
// Pixel fetch and 4-wire SPI panel bus between lcd_spi_stream (master) and lcd_draw/panel (slave).
interface lcd_spi_stream_if;
    logic [15:0] pixel_cnt;
    logic [15:0] pixel;
    logic        lcd_resetn;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_clk;
    logic        lcd_data;

    modport master (
        output pixel_cnt, lcd_resetn, lcd_cs, lcd_rs, lcd_clk, lcd_data,
        input  pixel
    );

    modport slave (
        input  pixel_cnt, lcd_resetn, lcd_cs, lcd_rs, lcd_clk, lcd_data,
        output pixel
    );
endinterface

// File: rtl/lcd_spi_stream.sv
// ST7789 bring-up (hardware reset, init ROM, address window) and RGB565 frame streaming over SPI mode 0.
// Macro LCD_CONTINUOUS_EN: when defined, frames repeat forever; otherwise the block idles after one frame.
module lcd_spi_stream #(
    parameter int H_RES        = 240,
    parameter int V_RES        = 135,
    parameter int CLK_DIV      = 2,
    parameter int RST_CYCLES   = 270000,
    parameter int DELAY_CYCLES = 3240000
) (
    input  logic              oscclk,
    input  logic              reset,
    lcd_spi_stream_if.master  bus,
    output logic              frame_done
);
    localparam logic [15:0]      PIX_LAST = 16'(H_RES * V_RES - 1);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] CS_LEAD  = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
    localparam logic [21:0]      RST_LAST = 22'(RST_CYCLES - 1);
    localparam logic [21:0]      DLY_LAST = 22'(DELAY_CYCLES - 1);
    localparam logic [4:0]       IDX_INIT_LAST = 5'd8;
    localparam logic [4:0]       IDX_WIN       = 5'd9;
    localparam logic [4:0]       IDX_WIN_LAST  = 5'd19;

    typedef enum logic [3:0] {
        RST_LOW, RST_WAIT, INIT, INIT_DLY, WINDOW, STREAM_HI, STREAM_LO, FRAME_END, IDLE
    } state_t;

    // {rs, byte}: entries 0..8 are the init commands, 9..19 the CASET/RASET/RAMWR window.
    function automatic logic [8:0] rom_entry(input logic [4:0] idx);
        case (idx)
            5'd0:    rom_entry = 9'h001;
            5'd1:    rom_entry = 9'h011;
            5'd2:    rom_entry = 9'h03A;
            5'd3:    rom_entry = 9'h155;
            5'd4:    rom_entry = 9'h036;
            5'd5:    rom_entry = 9'h170;
            5'd6:    rom_entry = 9'h021;
            5'd7:    rom_entry = 9'h013;
            5'd8:    rom_entry = 9'h029;
            5'd9:    rom_entry = 9'h02A;
            5'd10:   rom_entry = 9'h100;
            5'd11:   rom_entry = 9'h128;
            5'd12:   rom_entry = 9'h101;
            5'd13:   rom_entry = 9'h117;
            5'd14:   rom_entry = 9'h02B;
            5'd15:   rom_entry = 9'h100;
            5'd16:   rom_entry = 9'h135;
            5'd17:   rom_entry = 9'h100;
            5'd18:   rom_entry = 9'h1BB;
            default: rom_entry = 9'h02C;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [21:0]      cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [15:0]      pix_q, pix_d;
    logic [7:0]       lo_q, lo_d;
    logic             resetn_q, resetn_d;
    logic             fd_q, fd_d;

    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             rs_q, rs_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic             start;
    logic [7:0]       tx_byte;
    logic             tx_rs;
    logic             byte_end;
    logic             can_load;

    // byte_end is the edge that drops SCK after bit 0; a new byte may load on it (back-to-back)
    // or, once the engine is idle, only after lcd_cs has been raised.
    assign byte_end = busy_q && sck_q && (div_q == DIV_LAST) && (bit_q == 3'd0);
    assign can_load = byte_end || (!busy_q && cs_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pix_d    = pix_q;
        lo_d     = lo_q;
        resetn_d = resetn_q;
        fd_d     = 1'b0;
        start    = 1'b0;
        tx_byte  = 8'h00;
        tx_rs    = 1'b0;
        case (state_q)
            RST_LOW: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d    = 22'd0;
                    resetn_d = 1'b1;
                    state_d  = RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = 22'd0;
                    state_d = INIT;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            INIT: begin
                if (can_load) begin
                    start            = 1'b1;
                    {tx_rs, tx_byte} = rom_entry(idx_q);
                    idx_d            = idx_q + 5'd1;
                    if (idx_q <= 5'd1)
                        state_d = INIT_DLY;
                    else if (idx_q == IDX_INIT_LAST)
                        state_d = WINDOW;
                end
            end
            INIT_DLY: begin
                // The wait only counts once the command byte is out and lcd_cs is high again.
                if (!busy_q && cs_q) begin
                    if (cnt_q == DLY_LAST) begin
                        cnt_d   = 22'd0;
                        state_d = INIT;
                    end else begin
                        cnt_d = cnt_q + 22'd1;
                    end
                end
            end
            WINDOW: begin
                if (can_load) begin
                    start            = 1'b1;
                    {tx_rs, tx_byte} = rom_entry(idx_q);
                    if (idx_q == IDX_WIN_LAST) begin
                        idx_d   = IDX_WIN;
                        state_d = STREAM_HI;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            STREAM_HI: begin
                if (can_load) begin
                    start   = 1'b1;
                    tx_rs   = 1'b1;
                    tx_byte = bus.pixel[15:8];
                    lo_d    = bus.pixel[7:0];
                    state_d = STREAM_LO;
                end
            end
            STREAM_LO: begin
                if (can_load) begin
                    start   = 1'b1;
                    tx_rs   = 1'b1;
                    tx_byte = lo_q;
                    if (pix_q == PIX_LAST) begin
                        state_d = FRAME_END;
                    end else begin
                        pix_d   = pix_q + 16'd1;
                        state_d = STREAM_HI;
                    end
                end
            end
            FRAME_END: begin
                if (byte_end) begin
                    fd_d  = 1'b1;
                    pix_d = 16'd0;
`ifdef LCD_CONTINUOUS_EN
                    state_d = WINDOW;
`else
                    state_d = IDLE;
`endif
                end
            end
            IDLE: ;
            default: state_d = RST_LOW;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        sck_d  = sck_q;
        cs_d   = cs_q;
        mosi_d = mosi_q;
        rs_d   = rs_q;
        sh_d   = sh_q;
        bit_d  = bit_q;
        div_d  = div_q;
        if (start) begin
            busy_d = 1'b1;
            sck_d  = 1'b0;
            mosi_d = tx_byte[7];
            sh_d   = {tx_byte[6:0], 1'b0};
            rs_d   = tx_rs;
            bit_d  = 3'd7;
            div_d  = '0;
            if (CLK_DIV == 1)
                cs_d = 1'b0;
        end else if (busy_q) begin
            // With slower SCK, lcd_cs falls on the last cycle of the first low half-period.
            if (CLK_DIV > 1 && cs_q && !sck_q && div_q == CS_LEAD)
                cs_d = 1'b0;
            if (div_q == DIV_LAST) begin
                div_d = '0;
                sck_d = ~sck_q;
                if (sck_q) begin
                    if (bit_q == 3'd0) begin
                        busy_d = 1'b0;
                    end else begin
                        mosi_d = sh_q[7];
                        sh_d   = {sh_q[6:0], 1'b0};
                        bit_d  = bit_q - 3'd1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end else begin
            cs_d = 1'b1;
        end
    end

    always_ff @(posedge oscclk or negedge reset) begin
        if (!reset) begin
            state_q  <= RST_LOW;
            cnt_q    <= 22'd0;
            idx_q    <= 5'd0;
            pix_q    <= 16'd0;
            lo_q     <= 8'h00;
            resetn_q <= 1'b0;
            fd_q     <= 1'b0;
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            rs_q     <= 1'b0;
            sh_q     <= 8'h00;
            bit_q    <= 3'd0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pix_q    <= pix_d;
            lo_q     <= lo_d;
            resetn_q <= resetn_d;
            fd_q     <= fd_d;
            busy_q   <= busy_d;
            sck_q    <= sck_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            rs_q     <= rs_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
        end
    end

    assign bus.pixel_cnt  = pix_q;
    assign bus.lcd_resetn = resetn_q;
    assign bus.lcd_cs     = cs_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_clk    = sck_q;
    assign bus.lcd_data   = mosi_q;
    assign frame_done     = fd_q;
endmodule

// File: tb/tb_lcd_spi_stream.sv
// Scoreboard bench for lcd_spi_stream: expected SPI bytes are queued from the command list and pixel formula.
module tb_lcd_spi_stream;
    localparam int NPIX = 8;
    localparam logic [8:0] INIT_SEQ [0:8] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036,
                                              9'h170, 9'h021, 9'h013, 9'h029};
    localparam logic [8:0] WIN_SEQ [0:10] = '{9'h02A, 9'h100, 9'h128, 9'h101, 9'h117,
                                              9'h02B, 9'h100, 9'h135, 9'h100, 9'h1BB, 9'h02C};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_bytes = 0;
    int   fd_count = 0;
    logic [8:0] exp_q [$];

    lcd_spi_stream_if bus ();

    lcd_spi_stream #(
        .H_RES(4), .V_RES(2), .CLK_DIV(1), .RST_CYCLES(16), .DELAY_CYCLES(32)
    ) dut (
        .oscclk    (clk),
        .reset     (rst_n),
        .bus       (bus),
        .frame_done(frame_done)
    );

    // lcd_draw stand-in: colour is a pure function of the requested index.
    assign bus.pixel = {8'hA0 + bus.pixel_cnt[7:0], 8'h50 + bus.pixel_cnt[7:0]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic check_ge(input string name, input longint act, input longint lo);
        n_checks++;
        if (act >= lo) n_pass++;
        else $display("FAIL %s: got %0d, required at least %0d", name, act, lo);
    endtask

    task automatic push_window();
        foreach (WIN_SEQ[i]) exp_q.push_back(WIN_SEQ[i]);
    endtask

    task automatic push_frame();
        for (int p = 0; p < NPIX; p++) begin
            logic [7:0] pb;
            pb = 8'(p);
            exp_q.push_back({1'b1, 8'hA0 + pb});
            exp_q.push_back({1'b1, 8'h50 + pb});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resetn"},     bus.lcd_resetn, 0);
        check({tag, "_cs"},         bus.lcd_cs,     1);
        check({tag, "_sck"},        bus.lcd_clk,    0);
        check({tag, "_rs"},         bus.lcd_rs,     0);
        check({tag, "_mosi"},       bus.lcd_data,   0);
        check({tag, "_pixel_cnt"},  bus.pixel_cnt,  0);
        check({tag, "_frame_done"}, frame_done,     0);
    endtask

    // Releases reset (entered with rst_n low) and times the panel reset and first SCK edge.
    task automatic bringup();
        int n = 0;
        int t_rst = -1;
        int t_sck = -1;
        foreach (INIT_SEQ[i]) exp_q.push_back(INIT_SEQ[i]);
        push_window();
        push_frame();
        @(negedge clk);
        rst_n = 1'b1;
        while ((t_rst < 0 || t_sck < 0) && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (t_rst < 0 && bus.lcd_resetn) t_rst = n;
            if (t_sck < 0 && bus.lcd_clk) t_sck = n;
        end
        check("resetn_low_cycles", t_rst, 16);
        check_ge("first_sck_after_release", t_sck, 32);
    endtask

    // Monitor: deserialise on SCK rises while selected, pop the scoreboard, check timing side rules.
    logic       prev_sck = 1'b0, prev_cs = 1'b1, prev_fd = 1'b0;
    int         bitn = 0, first_cyc = 0, cs_run = 0;
    logic [7:0] shreg = 8'h00;
    logic       rs_first = 1'b0, rs_bad = 1'b0, last_valid = 1'b0;
    logic [8:0] last_byte = 9'h000, exp_b;
    logic [15:0] prev_pc = 16'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bitn = 0; prev_sck = 1'b0; prev_cs = 1'b1; prev_fd = 1'b0;
            cs_run = 0; last_valid = 1'b0; prev_pc = 16'd0; n_bytes = 0;
        end else begin
            if (!bus.lcd_cs && prev_cs) begin
                if (last_valid && (last_byte == 9'h001 || last_byte == 9'h011))
                    check_ge("cs_gap_after_delay_cmd", cs_run, 32);
                cs_run = 0;
            end
            if (bus.lcd_cs) cs_run++;
            if (bus.lcd_clk && !prev_sck && !bus.lcd_cs) begin
                if (bitn == 0) begin
                    first_cyc = cyc;
                    rs_first  = bus.lcd_rs;
                    rs_bad    = 1'b0;
                end else if (bus.lcd_rs != rs_first) begin
                    rs_bad = 1'b1;
                end
                shreg = {shreg[6:0], bus.lcd_data};
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    n_bytes++;
                    check("byte_span_rise0_to_rise7", cyc - first_cyc, 14);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        check("spi_byte_rs", {rs_bad, rs_first, shreg}, {1'b0, exp_b});
                    end else begin
                        n_checks++;
                        $display("FAIL spi_byte_extra: got 0x%0h, expected no byte", {rs_first, shreg});
                    end
                    last_byte  = {rs_first, shreg};
                    last_valid = 1'b1;
                end
            end
            if (bus.pixel_cnt != prev_pc) begin
                check("pixel_cnt_step", bus.pixel_cnt,
                      (int'(prev_pc) == NPIX - 1) ? 0 : int'(prev_pc) + 1);
                prev_pc = bus.pixel_cnt;
            end
            if (frame_done) begin
                check("frame_done_width", prev_fd, 0);
                check("frame_bytes_left", exp_q.size(), 0);
                check("pixel_cnt_at_frame_done", bus.pixel_cnt, 0);
                fd_count++;
            end
            prev_fd  = frame_done;
            prev_sck = bus.lcd_clk;
            prev_cs  = bus.lcd_cs;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        bringup();

        // Abort inside the third stream byte (byte index 22 overall).
        n = 0;
        while (n_bytes < 22 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check_ge("reached_stream", n_bytes, 22);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        repeat ($urandom_range(2, 5)) @(posedge clk);
        exp_q.delete();
        bringup();

        n = 0;
        while (fd_count < 1 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("first_frame_done", fd_count, 1);
`ifdef LCD_CONTINUOUS_EN
        push_window();
        push_frame();
        n = 0;
        while (fd_count < 2 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("second_frame_done", fd_count, 2);
        check("queue_drained", exp_q.size(), 0);
`else
        begin
            int   cs_low = 0;
            int   rises = 0;
            logic psck = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!bus.lcd_cs) cs_low++;
                if (bus.lcd_clk && !psck) rises++;
                psck = bus.lcd_clk;
            end
            check("idle_cs_low_cycles", cs_low, 0);
            check("idle_sck_rises", rises, 0);
            check("idle_pixel_cnt", bus.pixel_cnt, 0);
            check("frame_done_count", fd_count, 1);
            check("queue_drained", exp_q.size(), 0);
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lcd_spi_stream.md
Name: lcd_spi_stream

Overview:
- Display-side stage directly downstream of lcd_draw, which produces one RGB565 pixel per pixel_cnt value.
- This block drives pixel_cnt and consumes the returned pixel.
- It brings up the ST7789 240x135 panel: hardware reset, fixed init sequence, address window.
- It then streams frames over a 4-wire SPI (CS, DC/RS, SCK, MOSI).

Parameters:
- H_RES, 240, pixels per line.
- V_RES, 135, lines per frame; H_RES*V_RES must be at most 65536.
- CLK_DIV, 2, oscclk cycles per SCK half-period (1 or more).
- RST_CYCLES, 270000, oscclk cycles for the lcd_resetn low time, and again for the wait after release.
- DELAY_CYCLES, 3240000, oscclk cycles of wait after the SWRESET command and after the SLPOUT command.

Ports:
- oscclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pixel_cnt  out  16  linear pixel index to lcd_draw, 0..H_RES*V_RES-1.
- pixel  in  16  RGB565 colour for the current pixel_cnt (combinational from lcd_draw).
- lcd_resetn  out  1  panel hardware reset, active-low.
- lcd_cs  out  1  SPI chip select, active-low.
- lcd_rs  out  1  0 = command byte, 1 = data byte.
- lcd_clk  out  1  SPI SCK, mode 0, idles low.
- lcd_data  out  1  SPI MOSI, MSB first.
- frame_done  out  1  one-cycle pulse after the last pixel bit of a frame.

Behaviour:
- Reset (asynchronous, active-low, on oscclk): one clock domain, oscclk.
  - Outputs: lcd_resetn=0, lcd_cs=1, lcd_clk=0, lcd_rs=0, lcd_data=0, pixel_cnt=0, frame_done=0.
  - FSM enters RST_LOW and all counters clear.
  - Reset asserted mid-operation aborts the current byte immediately, with no completion.
- Byte engine: shifts 8 bits MSB first.
  - lcd_data and lcd_rs change only while lcd_clk is low.
  - lcd_clk toggles every CLK_DIV cycles, so one byte takes exactly 16*CLK_DIV oscclk cycles.
  - lcd_cs drops 1 cycle before the first SCK rise of a transfer and stays low between back-to-back bytes.
  - lcd_cs rises 1 cycle after the last falling edge of a transfer.
- FSM states and transitions:
  - RST_LOW: hold lcd_resetn=0 for RST_CYCLES, then go to RST_WAIT.
  - RST_WAIT: lcd_resetn=1, wait RST_CYCLES, then go to INIT.
  - INIT: send the ROM in order, listed as (rs, byte):
    - (0,01) SWRESET, then wait DELAY_CYCLES.
    - (0,11) SLPOUT, then wait DELAY_CYCLES.
    - (0,3A)(1,55) COLMOD.
    - (0,36)(1,70) MADCTL.
    - (0,21) INVON.
    - (0,13) NORON.
    - (0,29) DISPON.
    - lcd_cs is 1 during each wait.
  - WINDOW: send the following, then go to STREAM:
    - (0,2A)(1,00)(1,28)(1,01)(1,17) CASET, columns 40..279.
    - (0,2B)(1,00)(1,35)(1,00)(1,BB) RASET, rows 53..187.
    - (0,2C) RAMWR.
  - STREAM: for each pixel_cnt, send pixel[15:8] then pixel[7:0] with rs=1.
    - pixel is latched into the shifter when its high byte starts.
    - pixel_cnt increments when the low byte starts, so lcd_draw has at least 16*CLK_DIV cycles to settle.
    - lcd_cs stays low for the whole frame.
  - FRAME_END: after the low byte of pixel H_RES*V_RES-1, pulse frame_done for 1 cycle, set pixel_cnt to 0, raise lcd_cs, then take the macro-dependent next state.
- Arithmetic and wrap: pixel_cnt is compared against H_RES*V_RES-1 and never exceeds it.
  - Delay counters are 22 bits wide, which covers the default DELAY_CYCLES.

Optional Feature:
- Macro: LCD_CONTINUOUS_EN.
- Defined: FRAME_END goes back to WINDOW, so frames repeat indefinitely with a CASET/RASET/RAMWR before each frame.
- Undefined: FRAME_END goes to IDLE, which holds lcd_cs=1, lcd_clk=0 and pixel_cnt=0 until reset.
- Identical init and first-frame behaviour either way.

Test Plan:
Bench parameters for all scenarios: CLK_DIV=1, RST_CYCLES=16, DELAY_CYCLES=32, H_RES=4, V_RES=2.
1. Release reset -> lcd_resetn low for 16 cycles, then high; first SCK rise no earlier than 32 cycles after reset release; first captured byte is 0x01 with rs=0.
2. Capture all bytes on SCK rising edges while lcd_cs=0 -> exact init and window sequence 01,11,3A,55,36,70,21,13,29,2A,00,28,01,17,2B,00,35,00,BB,2C with the rs pattern above; gap after 0x01 and after 0x11 is at least 32 cycles with cs=1.
3. Bench model returns pixel = {8'hA0 + pixel_cnt[7:0], 8'h50 + pixel_cnt[7:0]} -> 16 stream bytes A0,50,A1,51,...,A7,57 (rs=1); pixel_cnt sequence 0..7 then 0; frame_done is a single high cycle after the last bit; each byte spans exactly 16 cycles.
4. Assert reset during the 3rd stream byte -> all outputs at reset values in the same cycle (asynchronous); after release, the full sequence restarts from RST_LOW.
5. With LCD_CONTINUOUS_EN -> second frame preceded by 2A..2C window bytes and frame_done pulses twice. Without LCD_CONTINUOUS_EN -> lcd_cs stays 1 and no SCK edges occur for 1000 cycles after the first frame_done.
